// File: rtl/e203_wbck_pkg.sv
// Shared long-pipe write-back types: payload struct, flag width and requester indices.
package e203_wbck_pkg;

    localparam int unsigned FLAGS_W = 5;

    localparam int unsigned DEF_FLEN        = 32;
    localparam int unsigned DEF_RFIDX_W     = 5;
    localparam int unsigned DEF_THREADS_NUM = 1;

    localparam int unsigned LSU    = 0;
    localparam int unsigned MULDIV = 1;
    localparam int unsigned NICE   = 2;
    localparam int unsigned FPU    = 3;

    typedef struct packed {
        logic [DEF_FLEN-1:0]        wdat;
        logic [FLAGS_W-1:0]         flags;
        logic [DEF_RFIDX_W-1:0]     rdidx;
        logic                       rdfpu;
        logic [DEF_THREADS_NUM-1:0] thread_sel;
    } wbck_pld_t;

    function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/e203_exu_longp_wbck_arb_if.sv
// Requester-side and write-back-side signals of the long-pipe write-back arbiter.
interface e203_exu_longp_wbck_arb_if #(
    parameter int unsigned REQ_NUM     = 4,
    parameter int unsigned THREADS_NUM = e203_wbck_pkg::DEF_THREADS_NUM,
    parameter int unsigned FLEN        = e203_wbck_pkg::DEF_FLEN,
    parameter int unsigned RFIDX_W     = e203_wbck_pkg::DEF_RFIDX_W
);
    localparam int unsigned FW    = e203_wbck_pkg::FLAGS_W;
    localparam int unsigned SRC_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [REQ_NUM-1:0]             req_valid;
    logic [REQ_NUM-1:0]             req_ready;
    logic [REQ_NUM*FLEN-1:0]        req_wdat;
    logic [REQ_NUM*FW-1:0]          req_flags;
    logic [REQ_NUM*RFIDX_W-1:0]     req_rdidx;
    logic [REQ_NUM-1:0]             req_rdfpu;
    logic [REQ_NUM*THREADS_NUM-1:0] req_thread_sel;

    logic                   o_valid;
    logic                   o_ready;
    logic [FLEN-1:0]        o_wdat;
    logic [FW-1:0]          o_flags;
    logic [RFIDX_W-1:0]     o_rdidx;
    logic                   o_rdfpu;
    logic [THREADS_NUM-1:0] o_thread_sel;
    logic [SRC_W-1:0]       o_src;

    modport slave (
        input  req_valid, req_wdat, req_flags, req_rdidx, req_rdfpu, req_thread_sel, o_ready,
        output req_ready, o_valid, o_wdat, o_flags, o_rdidx, o_rdfpu, o_thread_sel, o_src
    );

    modport master (
        output req_valid, req_wdat, req_flags, req_rdidx, req_rdfpu, req_thread_sel, o_ready,
        input  req_ready, o_valid, o_wdat, o_flags, o_rdidx, o_rdfpu, o_thread_sel, o_src
    );
endinterface

// File: rtl/e203_rr_arb.sv
// Round-robin grant: searches upward from ptr_i (wrapping) for the first set request.
module e203_rr_arb #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);
    int unsigned j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < N; off++) begin
            j = (32'(ptr_i) + off) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/e203_exu_longp_wbck_arb.sv
// Round-robin long-pipe write-back arbiter with a one-entry output register.
// Optional ALU-starvation yield guard enabled by E203_WBCK_ARB_STARVE_GUARD_EN.
module e203_exu_longp_wbck_arb
    import e203_wbck_pkg::*;
#(
    parameter int unsigned REQ_NUM      = 4,
    parameter int unsigned THREADS_NUM  = DEF_THREADS_NUM,
    parameter int unsigned FLEN         = DEF_FLEN,
    parameter int unsigned RFIDX_W      = DEF_RFIDX_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_stall,
    e203_exu_longp_wbck_arb_if.slave       bus
);
    localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic               yield;
    logic               load;
    logic [REQ_NUM-1:0] gnt;
    logic [PTR_W-1:0]   win_idx;
    logic               win_any;
    wbck_pld_t          win_pld;

    logic               oreg_vld_q, oreg_vld_d;
    wbck_pld_t          pld_q, pld_d;
    logic [PTR_W-1:0]   src_q, src_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

`ifdef E203_WBCK_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt_q, starve_cnt_d;

    // The count holds prior stalled cycles; the current stalled cycle completes the run.
    assign yield = alu_stall & (starve_cnt_q == 8'(STARVE_LIMIT - 1));

    always_comb begin
        starve_cnt_d = starve_cnt_q + 8'd1;
        if (yield || !alu_stall) starve_cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end
`else
    localparam int unsigned unused_starve_limit = STARVE_LIMIT;
    logic unused_alu_stall;
    assign unused_alu_stall = alu_stall;
    assign yield            = 1'b0;
`endif

    e203_rr_arb #(
        .N     (REQ_NUM),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .ptr_i (ptr_q),
        .req_i (bus.req_valid),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign bus.o_valid   = oreg_vld_q & ~yield;
    // Nothing is granted while reset is high, so un-granted entries stay with their owners.
    assign load          = (~oreg_vld_q | (bus.o_valid & bus.o_ready)) & ~yield & ~rst;
    assign bus.req_ready = {REQ_NUM{load}} & gnt;

    always_comb begin
        win_pld = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (gnt[i]) begin
                win_pld.wdat       = bus.req_wdat[i*FLEN +: FLEN];
                win_pld.flags      = bus.req_flags[i*FLAGS_W +: FLAGS_W];
                win_pld.rdidx      = bus.req_rdidx[i*RFIDX_W +: RFIDX_W];
                win_pld.rdfpu      = bus.req_rdfpu[i];
                win_pld.thread_sel = bus.req_thread_sel[i*THREADS_NUM +: THREADS_NUM];
            end
        end
    end

    always_comb begin
        oreg_vld_d = oreg_vld_q;
        pld_d      = pld_q;
        src_d      = src_q;
        ptr_d      = ptr_q;
        if (load) begin
            oreg_vld_d = win_any;
            if (win_any) begin
                pld_d = win_pld;
                src_d = win_idx;
                ptr_d = PTR_W'(rr_next(32'(win_idx), REQ_NUM));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oreg_vld_q <= 1'b0;
            pld_q      <= '0;
            src_q      <= '0;
            ptr_q      <= '0;
        end else begin
            oreg_vld_q <= oreg_vld_d;
            pld_q      <= pld_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.o_wdat       = pld_q.wdat;
    assign bus.o_flags      = pld_q.flags;
    assign bus.o_rdidx      = pld_q.rdidx;
    assign bus.o_rdfpu      = pld_q.rdfpu;
    assign bus.o_thread_sel = pld_q.thread_sel;
    assign bus.o_src        = src_q;
endmodule

// File: doc/e203_exu_longp_wbck_arb.md
# e203_exu_longp_wbck_arb

Round-robin arbiter that shares the single long-pipe write-back port among several long-latency producers (LSU, MULDIV, NICE, FPU). It sits directly ahead of the final write-back arbiter and drives its longp write-back interface through a one-entry output register. An optional guard briefly withholds long-pipe write-back so that a stalled ALU write-back is not starved.

## Interface
Parameters:
- REQ_NUM, 4, number of long-pipe requesters; index 0 is the LSU.
- THREADS_NUM, `E203_THREADS_NUM, width of the one-hot thread select.
- FLEN, `E203_FLEN, write-data width.
- RFIDX_W, `E203_RFIDX_WIDTH, register index width.
- STARVE_LIMIT, 8, ALU-stall cycles that trigger one yield cycle (range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  REQ_NUM  per-requester valid.
- req_ready  out  REQ_NUM  per-requester ready (one-hot grant).
- req_wdat  in  REQ_NUM*FLEN  packed write data; slice i belongs to requester i.
- req_flags  in  REQ_NUM*5  packed FP exception flags.
- req_rdidx  in  REQ_NUM*RFIDX_W  packed destination index.
- req_rdfpu  in  REQ_NUM  destination is the FP regfile.
- req_thread_sel  in  REQ_NUM*THREADS_NUM  packed one-hot thread select.
- o_valid  out  1  write-back valid toward longp_wbck_i_valid.
- o_ready  in  1  from longp_wbck_i_ready.
- o_wdat / o_flags / o_rdidx / o_rdfpu / o_thread_sel  out  FLEN / 5 / RFIDX_W / 1 / THREADS_NUM  registered payload.
- o_src  out  clog2(REQ_NUM)  index of the requester whose entry is held in the output register.
- alu_stall  in  1  ALU write-back is valid but not ready this cycle.

## Operation
Output register and load:
- The one-entry output register holds oreg_vld plus the payload.
- `load = (~oreg_vld | (o_valid & o_ready)) & ~yield`.

Round-robin grant:
- The pointer ptr is clog2(REQ_NUM) bits.
- Search starts at requester ptr and proceeds upward, wrapping modulo REQ_NUM. The first asserted req_valid wins.
- `req_ready[i] = load & win[i]`. At most one bit is set. req_ready may depend combinationally on req_valid.

On a grant of requester k:
- The payload of requester k loads into the output register, oreg_vld is set, and o_src becomes k.
- ptr becomes (k+1) mod REQ_NUM.

Other cycles:
- No grant and the output register drains: oreg_vld is cleared and ptr holds.
- Drain and grant in the same cycle: the register reloads, giving full throughput of 1 entry per cycle.
- Not drained: the payload and o_src hold stable, and req_ready is all zero.

Output valid:
- `o_valid = oreg_vld & ~yield`.
- The payload stays stable while o_valid is low due to yield.

Yield guard (when compiled in):
- starve_cnt increments each cycle alu_stall is 1 and clears when alu_stall is 0.
- When starve_cnt equals STARVE_LIMIT, yield is 1 for exactly that cycle, and starve_cnt is cleared on the next edge.
- In a yield cycle there is no load and no drain, and nothing is lost.

## Timing
- Reset values:
  - oreg_vld=0 and o_valid=0.
  - Payload, o_src and ptr are all 0.
  - starve_cnt=0, req_ready=0.
- Latency: a grant in cycle N makes o_valid high in cycle N+1.
- Sustained throughput is 1 write-back per cycle whenever o_ready is held at 1.
- All requesters valid, ptr=0, no stalls: grants go 0,1,2,3,0,…
- A single requester that stays valid is granted every cycle.
- Reset asserted mid-operation:
  - The held entry is discarded.
  - Requesters must retain any un-granted entries; this block grants nothing while rst is high.
- Simultaneous yield and a request: the request waits; the pointer does not advance.

## Configuration
- E203_WBCK_ARB_STARVE_GUARD_EN defined:
  - starve_cnt and the yield logic are present.
  - alu_stall is used.
- Not defined:
  - yield is tied to 0 and starve_cnt is absent.
  - alu_stall is unused.
  - STARVE_LIMIT is ignored.

## Structure
- Shared package, e203_wbck_pkg:
  - the write-back payload struct (wdat, flags, rdidx, rdfpu, thread_sel);
  - the FLAGS_W=5 constant;
  - the requester index constants (LSU=0, MULDIV=1, NICE=2, FPU=3).
- Sub-module e203_rr_arb: a parameterised round-robin grant of width N, taking a pointer and a request vector and producing a one-hot grant and the winning index. It is reusable elsewhere.
- The top level holds the output register, the pointer update and the yield counter.

## Test plan
- Reset then idle, rst released: all outputs are 0; req_valid=0001 gives req_ready=0001 immediately and o_valid=1 with o_src=0 next cycle.
- Fairness: req_valid=1111 held for 8 cycles with o_ready=1 gives o_src sequence 0,1,2,3,0,1,2,3 and 8 write-backs.
- Backpressure: o_ready=0 for 3 cycles with the output register full means req_ready=0000 and the payload (e.g. wdat=0xDEADBEEF, rdidx=5) holds; o_ready=1 then drains it and reloads in the same cycle.
- Wrap: ptr=3 with req_valid=1001 grants 3, then 0.
- Starve guard (macro on, STARVE_LIMIT=4): alu_stall=1 continuously with req_valid=0010 gives o_valid=0 exactly on cycle 4 of stall, payload unchanged, and resumes the next cycle. With the macro off there are no gaps.
- Mid-traffic reset: asserting rst while o_valid=1 clears o_valid within the same cycle (async); after release, the first grant starts from ptr=0.
